// File: rtl/loc_buffer_pkg.sv
// Shared encodings and default sizing for the LOC buffer.
package loc_buffer_pkg;
  typedef enum logic {
    STACK  = 1'b0,
    REPLAY = 1'b1
  } mode_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 64;
endpackage

// File: rtl/loc_buffer_if.sv
// Command and status bundle between a host and loc_buffer.
interface loc_buffer_if
  import loc_buffer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             push;
  logic             pop;
  logic             done;
  logic             restart;
  logic [WIDTH-1:0] locIn;
  logic [WIDTH-1:0] locOut;
  logic             outValid;
  logic             empStck;
  logic             full;
  logic [CNT_W-1:0] count;
  logic             mode;
  logic             ovf;
  logic             udf;

  modport master (
    output push, pop, done, restart, locIn,
    input  locOut, outValid, empStck, full, count, mode, ovf, udf
  );

  modport slave (
    input  push, pop, done, restart, locIn,
    output locOut, outValid, empStck, full, count, mode, ovf, udf
  );
endinterface

// File: rtl/loc_buffer_ram.sv
// Entry storage: one synchronous write port, one registered read port.
// Contents are never cleared; only the read register resets.
module loc_buffer_ram
  import loc_buffer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; no reset so the array maps onto plain storage.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register; returns the pre-write value when reading and writing the same address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/loc_buffer.sv
// LOC buffer: LIFO in STACK mode, in-order re-readable log in REPLAY mode.
module loc_buffer
  import loc_buffer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  loc_buffer_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] rd_q, rd_d;
  logic             ovf_q, ovf_d, udf_q, udf_d, valid_q, valid_d;
  logic             wr_en, rd_en;
  logic [AW-1:0]    wr_addr, rd_addr;
  logic [CNT_W-1:0] top_idx;
  logic             empty, is_full;

  assign top_idx = count_q - ONE;
  assign is_full = (count_q == DEPTH_C);
  assign empty   = (mode_q == STACK) ? (count_q == '0) : (rd_q == count_q);

  // Mode register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mode_q <= STACK;
    else     mode_q <= mode_d;
  end

  // Mode transitions: restart wins over done.
  always_comb begin
    mode_d = mode_q;
    if (bus.restart)   mode_d = STACK;
    else if (bus.done) mode_d = REPLAY;
  end

  // Per-cycle action decode: pointer/flag updates and RAM port controls.
  always_comb begin
    count_d = count_q;
    rd_d    = rd_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    valid_d = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_addr = count_q[AW-1:0];
    rd_addr = top_idx[AW-1:0];
    if (bus.restart) begin
      count_d = '0;
      rd_d    = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else if (bus.done) begin
      rd_d = '0;
    end else if (mode_q == STACK) begin
      if (bus.push && bus.pop) begin
        wr_en = 1'b1;
        if (!empty) begin
          // Swap: old top is read out while the same slot takes the new value.
          wr_addr = top_idx[AW-1:0];
          rd_en   = 1'b1;
          valid_d = 1'b1;
        end else begin
          count_d = count_q + ONE;
          udf_d   = 1'b1;
        end
      end else if (bus.push) begin
        if (is_full) begin
          ovf_d = 1'b1;
        end else begin
          wr_en   = 1'b1;
          count_d = count_q + ONE;
        end
      end else if (bus.pop) begin
        if (empty) begin
          udf_d = 1'b1;
        end else begin
          rd_en   = 1'b1;
          count_d = top_idx;
          valid_d = 1'b1;
        end
      end
    end else begin
      if (bus.push) ovf_d = 1'b1;
      if (bus.pop) begin
        if (empty) begin
          udf_d = 1'b1;
        end else begin
          rd_en   = 1'b1;
          rd_addr = rd_q[AW-1:0];
          rd_d    = rd_q + ONE;
          valid_d = 1'b1;
        end
      end
    end
  end

  // Pointer, flag and read-valid registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      rd_q    <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      rd_q    <= rd_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      valid_q <= valid_d;
    end
  end

  loc_buffer_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(bus.locIn),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_data(bus.locOut)
  );

  assign bus.outValid = valid_q;
  assign bus.empStck  = empty;
  assign bus.full     = is_full;
  assign bus.count    = count_q;
  assign bus.mode     = mode_q;
  assign bus.ovf      = ovf_q;
  assign bus.udf      = udf_q;
endmodule

// File: tb/tb_loc_buffer.sv
// Self-checking bench for loc_buffer against a queue-based reference model.
module tb_loc_buffer;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  loc_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  loc_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: stored entries oldest-first, replay index, flags, last read.
  logic [WIDTH-1:0] m_q[$];
  bit               m_mode;
  int               m_rd;
  bit               m_ovf, m_udf, m_valid;
  logic [WIDTH-1:0] m_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_mode  = 1'b0;
    m_rd    = 0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    m_valid = 1'b0;
    m_out   = '0;
  endtask

  task automatic model_step(input bit pu, input bit po, input bit dn, input bit rs,
                            input logic [WIDTH-1:0] d);
    m_valid = 1'b0;
    if (rs) begin
      m_q.delete();
      m_mode = 1'b0;
      m_rd   = 0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else if (dn) begin
      m_mode = 1'b1;
      m_rd   = 0;
    end else if (!m_mode) begin
      if (pu && po) begin
        if (m_q.size() > 0) begin
          m_out = m_q[m_q.size()-1];
          m_q[m_q.size()-1] = d;
          m_valid = 1'b1;
        end else begin
          m_q.push_back(d);
          m_udf = 1'b1;
        end
      end else if (pu) begin
        if (m_q.size() == DEPTH) m_ovf = 1'b1;
        else m_q.push_back(d);
      end else if (po) begin
        if (m_q.size() == 0) m_udf = 1'b1;
        else begin
          m_out = m_q.pop_back();
          m_valid = 1'b1;
        end
      end
    end else begin
      if (pu) m_ovf = 1'b1;
      if (po) begin
        if (m_rd == m_q.size()) m_udf = 1'b1;
        else begin
          m_out = m_q[m_rd];
          m_rd++;
          m_valid = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    bit exp_emp;
    exp_emp = m_mode ? (m_rd == m_q.size()) : (m_q.size() == 0);
    check({tag, ".locOut"},   32'(bus.locOut),   32'(m_out));
    check({tag, ".outValid"}, 32'(bus.outValid), 32'(m_valid));
    check({tag, ".empStck"},  32'(bus.empStck),  32'(exp_emp));
    check({tag, ".full"},     32'(bus.full),     32'(m_q.size() == DEPTH));
    check({tag, ".count"},    32'(bus.count),    32'(m_q.size()));
    check({tag, ".mode"},     32'(bus.mode),     32'(m_mode));
    check({tag, ".ovf"},      32'(bus.ovf),      32'(m_ovf));
    check({tag, ".udf"},      32'(bus.udf),      32'(m_udf));
  endtask

  task automatic cycle(input bit pu, input bit po, input bit dn, input bit rs,
                       input logic [WIDTH-1:0] d, input string tag);
    bus.push    = pu;
    bus.pop     = po;
    bus.done    = dn;
    bus.restart = rs;
    bus.locIn   = d;
    @(posedge clk);
    #1;
    model_step(pu, po, dn, rs, d);
    check_all(tag);
  endtask

  task automatic do_push(input logic [WIDTH-1:0] d); cycle(1, 0, 0, 0, d, "push"); endtask
  task automatic do_pop();     cycle(0, 1, 0, 0, '0, "pop");     endtask
  task automatic do_done();    cycle(0, 0, 1, 0, '0, "done");    endtask
  task automatic do_restart(); cycle(0, 0, 0, 1, '0, "restart"); endtask
  task automatic do_idle();    cycle(0, 0, 0, 0, '0, "idle");    endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.push = 0; bus.pop = 0; bus.done = 0; bus.restart = 0; bus.locIn = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    check("reset.empStck_lit", 32'(bus.empStck), 32'd1);
    rst = 1'b0;

    // LIFO order
    do_push(8'h12); do_push(8'h34); do_push(8'h56);
    do_pop(); check("lifo0", 32'(bus.locOut), 32'h56);
    do_pop(); check("lifo1", 32'(bus.locOut), 32'h34);
    do_pop(); check("lifo2", 32'(bus.locOut), 32'h12);
    check("lifo.valid", 32'(bus.outValid), 32'd1);
    do_idle(); check("lifo.empty", 32'(bus.empStck), 32'd1);

    // Replay in push order, repeatable
    do_push(8'h12); do_push(8'h34); do_push(8'h56);
    do_done();
    do_pop(); check("rep0", 32'(bus.locOut), 32'h12);
    do_pop(); check("rep1", 32'(bus.locOut), 32'h34);
    do_pop(); check("rep2", 32'(bus.locOut), 32'h56);
    check("rep.count", 32'(bus.count), 32'd3);
    check("rep.empty", 32'(bus.empStck), 32'd1);
    do_done();
    do_pop(); check("rep.again", 32'(bus.locOut), 32'h12);

    // Full / overflow
    do_restart();
    do_push(8'hA1); do_push(8'hA2); do_push(8'hA3); do_push(8'hA4);
    check("full.after4", 32'(bus.full), 32'd1);
    do_push(8'hA5);
    check("ovf.after5", 32'(bus.ovf), 32'd1);
    check("ovf.count", 32'(bus.count), 32'd4);
    do_pop(); check("ovf.pop", 32'(bus.locOut), 32'hA4);

    // Underflow and push+pop swap
    do_restart();
    do_pop();
    check("udf.flag", 32'(bus.udf), 32'd1);
    check("udf.valid", 32'(bus.outValid), 32'd0);
    do_push(8'h11);
    cycle(1, 1, 0, 0, 8'hAA, "swap");
    check("swap.out", 32'(bus.locOut), 32'h11);
    check("swap.count", 32'(bus.count), 32'd1);
    do_pop(); check("swap.top", 32'(bus.locOut), 32'hAA);

    // Asynchronous reset mid-replay with a pop pending
    do_restart();
    do_push(8'h21); do_push(8'h22); do_push(8'h23);
    do_done();
    do_pop();
    bus.pop = 1'b1;
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all("arst");
    check("arst.mode", 32'(bus.mode), 32'd0);
    check("arst.count", 32'(bus.count), 32'd0);
    @(posedge clk);
    #1;
    check("arst.abort", 32'(bus.outValid), 32'd0);
    bus.pop = 1'b0;
    rst = 1'b0;

    // restart clears flags and mode
    do_push(8'h31); do_pop(); do_pop();
    do_done(); do_push(8'h32);
    do_restart();
    check("rst2.count", 32'(bus.count), 32'd0);
    check("rst2.mode", 32'(bus.mode), 32'd0);
    check("rst2.ovf", 32'(bus.ovf), 32'd0);
    check("rst2.udf", 32'(bus.udf), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit pu, po, dn, rs;
      pu = ($urandom_range(0, 99) < 50);
      po = ($urandom_range(0, 99) < 45);
      dn = ($urandom_range(0, 99) < 5);
      rs = ($urandom_range(0, 99) < 3);
      cycle(pu, po, dn, rs, WIDTH'($urandom), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/loc_buffer.md
LOC_BUFFER -- requirements
Module: loc_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, entry width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, entry count; power of two, >= 2.
REQ-003 SHALL derive CNT_W = clog2(DEPTH)+1 internally, not overridable.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 push  in  1  write locIn.
REQ-007 pop  in  1  read one entry; removes it in STACK mode, advances the replay pointer in REPLAY mode.
REQ-008 done  in  1  switch to REPLAY, rewinding the read pointer to the oldest entry.
REQ-009 restart  in  1  synchronous clear; return to STACK with zero entries.
REQ-010 locIn  in  WIDTH  write data.
REQ-011 locOut  out  WIDTH  registered read data; holds its last value between reads.
REQ-012 outValid  out  1  high for exactly the cycle after an accepted pop.
REQ-013 empStck  out  1  no readable entry in the current mode.
REQ-014 full  out  1  count == DEPTH.
REQ-015 count  out  CNT_W  stored entries.
REQ-016 mode  out  1  0 = STACK, 1 = REPLAY.
REQ-017 ovf  out  1  sticky overflow/illegal-push flag.
REQ-018 udf  out  1  sticky underflow flag.

Function
REQ-019 SHALL implement a two-state FSM, STACK and REPLAY; STACK is entered on reset and on restart; REPLAY is entered on done in either state.
REQ-020 Entries SHALL occupy mem[0..count-1]; the top of stack is mem[count-1].
REQ-021 STACK push (not full): write mem[count] = locIn, count+1.
REQ-022 STACK pop (not empty): locOut = mem[count-1], count-1, outValid next cycle.
REQ-023 STACK push+pop same cycle, count > 0: locOut = old top, top overwritten with locIn, count unchanged, outValid=1.
REQ-024 STACK push+pop same cycle, count == 0: push accepted, pop rejected, udf set.
REQ-025 Push when full with no simultaneous pop: data dropped, state unchanged, ovf set.
REQ-026 Pop when empStck: locOut unchanged, outValid stays 0, udf set.
REQ-027 In STACK mode, empStck SHALL equal (count == 0).
REQ-028 REPLAY: rd pointer starts at 0; pop returns mem[rd] and increments rd; count is not modified.
REQ-029 In REPLAY mode, empStck SHALL equal (rd == count).
REQ-030 Push in REPLAY: ignored, ovf set.
REQ-031 done in REPLAY SHALL rewind rd to 0 (replay again).
REQ-032 Priority per cycle SHALL be restart > done > push/pop; push/pop in the same cycle as done or restart SHALL be ignored without setting flags.
REQ-033 Read latency SHALL be exactly one cycle; pops MAY be accepted on back-to-back cycles.
REQ-034 count and rd SHALL never wrap; all arithmetic SHALL be CNT_W bits wide.
REQ-035 ovf and udf SHALL clear only on rst or restart.

Reset
REQ-036 rst high SHALL immediately force mode=STACK, count=0, rd=0, locOut=0, outValid=0, ovf=0, udf=0, empStck=1, full=0.
REQ-037 Memory contents SHALL NOT be cleared by rst or restart; unwritten entries SHALL be unobservable.
REQ-038 rst asserted mid-operation SHALL abort any pop in flight, leaving outValid 0 on the following cycle.

Structure
REQ-039 Package loc_buffer_pkg SHALL hold the mode encodings (STACK/REPLAY) and the default WIDTH/DEPTH constants.
REQ-040 Storage SHALL be a sub-module loc_buffer_ram (one synchronous write port, one registered read port); the FSM, pointers and flags SHALL reside in loc_buffer.

Verification
REQ-041 Push 0x12, 0x34, 0x56, then 3 pops -> locOut 0x56, 0x34, 0x12 on consecutive cycles, outValid=1 each, then empStck=1.
REQ-042 Push 0x12, 0x34, 0x56, done, 3 pops -> locOut 0x12, 0x34, 0x56, count stays 3, empStck=1 after; done again, pop -> 0x12.
REQ-043 DEPTH=4: 5 pushes -> full=1 after the 4th, ovf=1 after the 5th, count=4; pop -> the 4th value.
REQ-044 Empty pop -> udf=1, outValid=0; push 0xAA+pop with count 1 (top 0x11) -> locOut 0x11, top 0xAA, count 1.
REQ-045 Assert rst asynchronously between edges mid-replay -> all outputs at reset values before the next edge; restart -> count=0, mode=0, flags cleared.
